// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder and its companion
// binary-to-segment encoder.
//   SEG_0..SEG_9 : active-high {a,b,c,d,e,f,g} codes, a in bit 6, g in bit 0
//   state_e      : scan decoder FSM states
//   is_onehot4   : true when exactly one bit of a 4-bit vector is set
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam logic [3:0] NIBBLE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder.
//   seg_i     : segment pattern {a,b,c,d,e,f,g}
//   nibble_o  : decoded digit 0..9, or 4'hF for an unknown pattern
//   invalid_o : high when the pattern is not one of the ten digit codes
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = NIBBLE_INVALID;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:   nibble_o = 4'd0;
      SEG_1:   nibble_o = 4'd1;
      SEG_2:   nibble_o = 4'd2;
      SEG_3:   nibble_o = 4'd3;
      SEG_4:   nibble_o = 4'd4;
      SEG_5:   nibble_o = 4'd5;
      SEG_6:   nibble_o = 4'd6;
      SEG_7:   nibble_o = 4'd7;
      SEG_8:   nibble_o = 4'd8;
      SEG_9:   nibble_o = 4'd9;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the four digits of a multiplexed seven-segment display by
// watching its segment and anode lines.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   seg         : segment lines {a,b,c,d,e,f,g}, a = bit 6
//   an          : active-high digit select, one-hot while a digit is shown
//   bcd_out     : last complete frame, digit i in bits [4i+3:4i]
//   err_out     : per-digit flag, set where the pattern was unrecognised
//   frame_valid : one-cycle pulse when bcd_out/err_out update
//
// state  | meaning
// IDLE   | no digit selected (an not one-hot), waiting
// SETTLE | one digit selected, counting identical samples
// HOLD   | digit captured, ignoring it until {an,seg} changes
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd_out,
  output logic [3:0]  err_out,
  output logic        frame_valid
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [6:0]  seg_q, seg_prev_q;
  logic [3:0]  an_q, an_prev_q;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]  captured_q, captured_d;
  logic [15:0] shadow_bcd_q, shadow_bcd_d;
  logic [3:0]  shadow_err_q, shadow_err_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  err_q, err_d;
  logic        fv_q, fv_d;

  logic [3:0]  dec_nibble;
  logic        dec_invalid;
  logic        sample_changed;
  logic        capture;
  logic        frame_fire;

  seg7_pattern_decode u_decode (
    .seg_i     (seg_q),
    .nibble_o  (dec_nibble),
    .invalid_o (dec_invalid)
  );

  assign sample_changed = {an_q, seg_q} != {an_prev_q, seg_prev_q};
  assign cnt_inc        = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot4(an_q)) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      ST_SETTLE, ST_HOLD: begin
        if (sample_changed) begin
          if (is_onehot4(an_q)) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end else if (state_q == ST_SETTLE) begin
          cnt_d = cnt_inc;
          // Capture as soon as the count reaches the threshold so the
          // shadow slot is written in the same cycle the FSM enters HOLD.
          if (cnt_inc >= STABLE_CNT) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    shadow_bcd_d = shadow_bcd_q;
    shadow_err_d = shadow_err_q;
    for (int i = 0; i < 4; i++) begin
      if (capture && an_q[i]) begin
        shadow_bcd_d[4*i +: 4] = dec_nibble;
        shadow_err_d[i]        = dec_invalid;
      end
    end

    frame_fire = (captured_q == 4'b1111);
    // A capture landing on the clear cycle keeps its captured bit; the
    // frame copy below still takes the pre-capture shadow contents.
    captured_d = (frame_fire ? 4'b0000 : captured_q) | (capture ? an_q : 4'b0000);

    bcd_d = bcd_q;
    err_d = err_q;
    fv_d  = 1'b0;
    if (frame_fire) begin
      bcd_d = shadow_bcd_q;
      err_d = shadow_err_q;
      fv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= 7'h00;
      an_q         <= 4'h0;
      seg_prev_q   <= 7'h00;
      an_prev_q    <= 4'h0;
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      captured_q   <= 4'b0000;
      shadow_bcd_q <= 16'h0000;
      shadow_err_q <= 4'h0;
      bcd_q        <= 16'h0000;
      err_q        <= 4'h0;
      fv_q         <= 1'b0;
    end else begin
      seg_q        <= seg;
      an_q         <= an;
      seg_prev_q   <= seg_q;
      an_prev_q    <= an_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_err_q <= shadow_err_d;
      bcd_q        <= bcd_d;
      err_q        <= err_d;
      fv_q         <= fv_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign err_out     = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  an = 4'h0;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        frame_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int          fv_count = 0;
  logic [15:0] fv_bcd[$];
  logic [3:0]  fv_err[$];

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .bcd_out     (bcd_out),
    .err_out     (err_out),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      fv_bcd.push_back(bcd_out);
      fv_err.push_back(err_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    an    = 4'h0;
    seg   = 7'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    show(4'b0001, s0, 8);
    show(4'b0010, s1, 8);
    show(4'b0100, s2, 8);
    show(4'b1000, s3, 8);
    show(4'b0000, 7'h00, 4);
  endtask

  task automatic test_reset();
    int base;
    base = fv_count;
    @(negedge clk);
    rst_n = 1'b0;
    an    = 4'b0001;
    seg   = SEG_1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bcd_out !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h want %h", bcd_out, 16'h0000); end
    n_checks++;
    if (err_out !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %h want %h", err_out, 4'h0); end
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    n_checks++;
    if (fv_count - base != 0) begin n_fail++; $display("FAIL reset_no_pulse: got %0d pulses want 0", fv_count - base); end
    an = 4'h0;
    do_reset();
  endtask

  task automatic test_basic();
    int base;
    logic [15:0] got_b;
    logic [3:0]  got_e;
    do_reset();
    base = fv_count;
    show(4'b0001, SEG_1, 10);
    show(4'b0010, SEG_5, 8);
    show(4'b0100, SEG_7, 8);
    show(4'b1000, SEG_8, 8);
    show(4'b0000, 7'h00, 4);
    got_b = 16'hxxxx;
    got_e = 4'hx;
    if (fv_bcd.size() > base) begin got_b = fv_bcd[base]; got_e = fv_err[base]; end
    n_checks++;
    if (fv_count - base != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", fv_count - base); end
    n_checks++;
    if (got_b !== 16'h8751) begin n_fail++; $display("FAIL basic_frame_bcd: got %h want %h", got_b, 16'h8751); end
    n_checks++;
    if (got_e !== 4'h0) begin n_fail++; $display("FAIL basic_frame_err: got %h want %h", got_e, 4'h0); end
    n_checks++;
    if (bcd_out !== 16'h8751) begin n_fail++; $display("FAIL basic_bcd_hold: got %h want %h", bcd_out, 16'h8751); end
  endtask

  task automatic test_latency();
    do_reset();
    show(4'b0001, SEG_0, 8);
    show(4'b0010, SEG_1, 8);
    show(4'b0100, SEG_2, 8);
    @(negedge clk);
    an  = 4'b1000;
    seg = SEG_3;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k >= 5) begin
        n_checks++;
        if (frame_valid !== (k == 6)) begin
          n_fail++;
          $display("FAIL latency_fv_edge%0d: got %b want %b", k, frame_valid, (k == 6));
        end
      end
    end
    show(4'b0000, 7'h00, 4);
    n_checks++;
    if (bcd_out !== 16'h3210) begin n_fail++; $display("FAIL latency_bcd: got %h want %h", bcd_out, 16'h3210); end
  endtask

  task automatic test_unstable();
    int base;
    do_reset();
    base = fv_count;
    for (int r = 0; r < 8; r++) show(4'b0010, (r % 2 == 1) ? SEG_3 : SEG_2, 3);
    n_checks++;
    if (dut.captured_q[1] !== 1'b0) begin n_fail++; $display("FAIL unstable_captured1: got %b want 0", dut.captured_q[1]); end
    show(4'b0001, SEG_0, 8);
    show(4'b0100, SEG_2, 8);
    show(4'b1000, SEG_3, 8);
    show(4'b0000, 7'h00, 4);
    n_checks++;
    if (fv_count - base != 0) begin n_fail++; $display("FAIL unstable_pulses: got %0d want 0", fv_count - base); end
  endtask

  task automatic test_blank();
    int base;
    logic [3:0] got_e;
    do_reset();
    base = fv_count;
    scan4(SEG_0, SEG_1, 7'h00, SEG_3);
    got_e = 4'hx;
    if (fv_err.size() > base) got_e = fv_err[base];
    n_checks++;
    if (fv_count - base != 1) begin n_fail++; $display("FAIL blank_pulses: got %0d want 1", fv_count - base); end
    n_checks++;
    if (bcd_out !== 16'h3F10) begin n_fail++; $display("FAIL blank_bcd: got %h want %h", bcd_out, 16'h3F10); end
    n_checks++;
    if (got_e !== 4'b0100) begin n_fail++; $display("FAIL blank_err: got %b want %b", got_e, 4'b0100); end
  endtask

  task automatic test_not_onehot();
    int base;
    do_reset();
    base = fv_count;
    show(4'b0011, SEG_0, 20);
    #1;
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL notonehot_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    n_checks++;
    if (dut.captured_q !== 4'b0000) begin n_fail++; $display("FAIL notonehot_captured: got %b want 0000", dut.captured_q); end
    show(4'b0000, SEG_1, 5);
    #1;
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL zero_an_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    show(4'b0010, SEG_1, 8);
    show(4'b0100, SEG_2, 8);
    show(4'b1000, SEG_3, 8);
    show(4'b0000, 7'h00, 4);
    n_checks++;
    if (fv_count - base != 0) begin n_fail++; $display("FAIL notonehot_pulses: got %0d want 0", fv_count - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [15:0] got_b;
    do_reset();
    base = fv_count;
    show(4'b0001, SEG_9, 8);
    show(4'b0010, SEG_9, 8);
    show(4'b0100, SEG_9, 8);
    show(4'b1000, SEG_9, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bcd_out !== 16'h0000 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got bcd %h fv %b want 0000/0", bcd_out, frame_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    an    = 4'h0;
    seg   = 7'h00;
    repeat (5) @(negedge clk);
    n_checks++;
    if (fv_count - base != 0) begin n_fail++; $display("FAIL midreset_release_pulse: got %0d want 0", fv_count - base); end
    scan4(SEG_4, SEG_5, SEG_6, SEG_7);
    got_b = 16'hxxxx;
    if (fv_bcd.size() > base) got_b = fv_bcd[base];
    n_checks++;
    if (fv_count - base != 1) begin n_fail++; $display("FAIL midreset_pulses: got %0d want 1", fv_count - base); end
    n_checks++;
    if (got_b !== 16'h7654) begin n_fail++; $display("FAIL midreset_bcd: got %h want %h", got_b, 16'h7654); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [15:0] got_b;
    do_reset();
    base = fv_count;
    scan4(SEG_0, SEG_1, SEG_2, SEG_3);
    n_checks++;
    if (bcd_out !== 16'h3210) begin n_fail++; $display("FAIL b2b_first_bcd: got %h want %h", bcd_out, 16'h3210); end
    show(4'b0001, SEG_9, 8);
    n_checks++;
    if (bcd_out !== 16'h3210) begin n_fail++; $display("FAIL b2b_hold_stable: got %h want %h", bcd_out, 16'h3210); end
    show(4'b0010, SEG_1, 8);
    show(4'b0100, SEG_2, 8);
    show(4'b1000, SEG_3, 8);
    show(4'b0000, 7'h00, 4);
    got_b = 16'hxxxx;
    if (fv_bcd.size() > base + 1) got_b = fv_bcd[base + 1];
    n_checks++;
    if (fv_count - base != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", fv_count - base); end
    n_checks++;
    if (got_b !== 16'h3219) begin n_fail++; $display("FAIL b2b_second_bcd: got %h want %h", got_b, 16'h3219); end
  endtask

  task automatic test_recapture();
    int base;
    do_reset();
    base = fv_count;
    show(4'b0001, SEG_1, 8);
    show(4'b0010, SEG_4, 8);
    show(4'b0001, SEG_2, 8);
    show(4'b0100, SEG_6, 8);
    show(4'b1000, SEG_8, 8);
    show(4'b0000, 7'h00, 4);
    n_checks++;
    if (fv_count - base != 1) begin n_fail++; $display("FAIL recapture_pulses: got %0d want 1", fv_count - base); end
    n_checks++;
    if (bcd_out !== 16'h8642) begin n_fail++; $display("FAIL recapture_bcd: got %h want %h", bcd_out, 16'h8642); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_unstable();
    test_blank();
    test_not_onehot();
    test_reset_mid();
    test_back_to_back();
    test_recapture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
